// File: rtl/gate_bist_ctrl_if.sv
// gate_bist_ctrl_if: run-control and status bundle of the gate BIST controller.
// The master side starts/aborts runs; the slave side (the controller) reports
// progress, completion, the running signature and the pass verdict.
interface gate_bist_ctrl_if #(
   parameter int OUT_W = 10,
   parameter int CNT_W = 11
);
   logic             start_i;
   logic             abort_i;
   logic             busy_o;
   logic             done_o;
   logic             pass_o;
   logic [OUT_W-1:0] signature_o;
   logic [CNT_W-1:0] pat_idx_o;

   modport master (
      output start_i, abort_i,
      input  busy_o, done_o, pass_o, signature_o, pat_idx_o
   );

   modport slave (
      input  start_i, abort_i,
      output busy_o, done_o, pass_o, signature_o, pat_idx_o
   );
endinterface

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: LFSR stimulus / MISR response self-test loop around a
// combinational gate-model netlist. Each pattern is applied, allowed to settle,
// then folded into the signature; after the last pattern the signature is
// compared with the golden value.
module gate_bist_ctrl #(
   parameter int              IN_W       = 18,
   parameter int              OUT_W      = 10,
   parameter int              PAT_CNT    = 1024,
   parameter int              SETTLE_CYC = 2,
   parameter logic [IN_W-1:0]  LFSR_SEED  = 'h00001,
   parameter logic [IN_W-1:0]  LFSR_POLY  = 'h00801,
   parameter logic [OUT_W-1:0] MISR_POLY  = 'h009,
   parameter logic [OUT_W-1:0] GOLDEN_SIG = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   gate_bist_ctrl_if.slave  ctl,
   output logic [IN_W-1:0]  dut_in_o,
   input  logic [OUT_W-1:0] dut_out_i
);

   // The interface instance must be built with CNT_W = $clog2(PAT_CNT+1).
   localparam int               CNT_W     = $clog2(PAT_CNT + 1);
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(PAT_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(PAT_CNT);
   // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
   localparam logic [IN_W-1:0]  SEED      = (LFSR_SEED == '0) ? IN_W'(1) : LFSR_SEED;
   localparam int               WAIT_W    = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      SETTLE,
      CAPTURE,
      DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [IN_W-1:0]   lfsr;
   logic [OUT_W-1:0]  misr;
   logic [CNT_W-1:0]  count;
   logic [WAIT_W-1:0] wait_cnt;
   logic              pass;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // pre-edge values; blocking here would create order-dependent races.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode; abort overrides every transition, including a start in IDLE.
   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      if (ctl.abort_i) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (ctl.start_i) state_nxt = APPLY;
            APPLY:   state_nxt = (SETTLE_CYC == 0) ? CAPTURE : SETTLE;
            SETTLE:  if (wait_cnt == WAIT_LAST) state_nxt = CAPTURE;
            CAPTURE: state_nxt = (count == LAST_IDX) ? DONE : APPLY;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Datapath: stimulus generation, response compaction, pattern count, verdict.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr     <= SEED;
         misr     <= '0;
         count    <= '0;
         wait_cnt <= '0;
         pass     <= 1'b0;
         dut_in_o <= '0;
      end else if (ctl.abort_i) begin
         // Partial signature, count and stimulus are left visible for debug.
         if (state != IDLE) pass <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ctl.start_i) begin
                  lfsr  <= SEED;
                  misr  <= '0;
                  count <= '0;
                  pass  <= 1'b0;
               end
            end
            APPLY: begin
               dut_in_o <= lfsr;
               wait_cnt <= '0;
            end
            SETTLE: wait_cnt <= wait_cnt + 1'b1;
            CAPTURE: begin
               misr <= ({misr[OUT_W-2:0], 1'b0} ^ (misr[OUT_W-1] ? MISR_POLY : '0)) ^ dut_out_i;
               lfsr <= {lfsr[IN_W-2:0], 1'b0} ^ (lfsr[IN_W-1] ? LFSR_POLY : '0);
               if (count != CNT_MAX) count <= count + 1'b1;
            end
            DONE: pass <= (misr == GOLDEN_SIG);
            default: ;
         endcase
      end
   end

   // Status outputs decoded from the registered state.
   assign ctl.busy_o      = (state == APPLY) || (state == SETTLE) || (state == CAPTURE);
   assign ctl.done_o      = (state == DONE) && !ctl.abort_i;
   assign ctl.pass_o      = pass;
   assign ctl.signature_o = misr;
   assign ctl.pat_idx_o   = count;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// tb_gate_bist_ctrl: directed and randomized checks of gate_bist_ctrl.
// Instance A: 4 patterns, no settle cycles. Instance B: 19 patterns, 2 settle cycles.
// A modelled netlist (identity, stuck-at-ones, or a keyed hash) closes each loop.
module tb_gate_bist_ctrl;

   localparam int IN_W   = 18;
   localparam int OUT_W  = 10;
   localparam int PAT_A  = 4;
   localparam int SET_A  = 0;
   localparam int PAT_B  = 19;
   localparam int SET_B  = 2;
   localparam int CNTW_A = $clog2(PAT_A + 1);
   localparam int CNTW_B = $clog2(PAT_B + 1);

   typedef enum {O_DIN, O_BUSY, O_DONE, O_PASS, O_SIG, O_IDX} obs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [IN_W-1:0]  din_a, din_b;
   logic [OUT_W-1:0] dout_a, dout_b;
   int               mode_a = 0, mode_b = 0;
   logic [31:0]      key_a = 0, key_b = 0;
   logic [IN_W-1:0]  exp_pats[$];

   gate_bist_ctrl_if #(.OUT_W(OUT_W), .CNT_W(CNTW_A)) ifa ();
   gate_bist_ctrl_if #(.OUT_W(OUT_W), .CNT_W(CNTW_B)) ifb ();

   gate_bist_ctrl #(.PAT_CNT(PAT_A), .SETTLE_CYC(SET_A)) u_a (
      .clk(clk), .rst_n(rst_n), .ctl(ifa.slave), .dut_in_o(din_a), .dut_out_i(dout_a)
   );
   gate_bist_ctrl #(.PAT_CNT(PAT_B), .SETTLE_CYC(SET_B)) u_b (
      .clk(clk), .rst_n(rst_n), .ctl(ifb.slave), .dut_in_o(din_b), .dut_out_i(dout_b)
   );

   // Netlist model: 0 identity, 1 stuck at all ones, 2 keyed hash.
   function automatic logic [OUT_W-1:0] resp(input int mode, input logic [31:0] key,
                                             input logic [IN_W-1:0] x);
      logic [31:0] t;
      t = (32'(x) * key) ^ (32'(x) >> 5);
      case (mode)
         0:       return x[OUT_W-1:0];
         1:       return 10'h3FF;
         default: return t[OUT_W-1:0];
      endcase
   endfunction

   assign dout_a = resp(mode_a, key_a, din_a);
   assign dout_b = resp(mode_b, key_b, din_b);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] obs(input bit sel, input obs_t w);
      if (sel) begin
         case (w)
            O_DIN:   return 32'(din_b);
            O_BUSY:  return 32'(ifb.busy_o);
            O_DONE:  return 32'(ifb.done_o);
            O_PASS:  return 32'(ifb.pass_o);
            O_SIG:   return 32'(ifb.signature_o);
            default: return 32'(ifb.pat_idx_o);
         endcase
      end
      case (w)
         O_DIN:   return 32'(din_a);
         O_BUSY:  return 32'(ifa.busy_o);
         O_DONE:  return 32'(ifa.done_o);
         O_PASS:  return 32'(ifa.pass_o);
         O_SIG:   return 32'(ifa.signature_o);
         default: return 32'(ifa.pat_idx_o);
      endcase
   endfunction

   task automatic drive_start(input bit sel, input bit v);
      if (sel) ifb.start_i = v;
      else     ifa.start_i = v;
   endtask

   // Reference run: stimulus is the seed times successive powers of x modulo
   // x^18+x^11+1; the signature is the polynomial fold of the responses
   // modulo x^10+x^3+1. Fills exp_pats with the applied patterns.
   task automatic model(input int n, input int mode, input logic [31:0] key,
                        output logic [OUT_W-1:0] sig);
      logic [IN_W-1:0] x;
      logic [IN_W:0]   y;
      logic [OUT_W:0]  m;
      exp_pats.delete();
      x   = 18'h00001;
      sig = '0;
      for (int i = 0; i < n; i++) begin
         exp_pats.push_back(x);
         m = {sig, 1'b0};
         if (m[OUT_W]) m = m ^ 11'h409;
         sig = m[OUT_W-1:0] ^ resp(mode, key, x);
         y = {x, 1'b0};
         if (y[IN_W]) y = y ^ 19'h40801;
         x = y[IN_W-1:0];
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int s = 0; s < 2; s++) begin
         check({tag, "_din"},  obs(s[0], O_DIN),  0);
         check({tag, "_busy"}, obs(s[0], O_BUSY), 0);
         check({tag, "_done"}, obs(s[0], O_DONE), 0);
         check({tag, "_pass"}, obs(s[0], O_PASS), 0);
         check({tag, "_sig"},  obs(s[0], O_SIG),  0);
         check({tag, "_idx"},  obs(s[0], O_IDX),  0);
      end
   endtask

   // One complete run with optional start pulse during the 2nd pattern.
   task automatic run(input string tag, input bit sel, input int mode,
                      input logic [31:0] key, input bit poke);
      int pc, per, done_at, pulses, din_bad, busy_bad;
      logic [OUT_W-1:0] sig;
      logic [31:0]      p19;
      pc  = sel ? PAT_B : PAT_A;
      per = (sel ? SET_B : SET_A) + 2;
      if (sel) begin mode_b = mode; key_b = key; end
      else     begin mode_a = mode; key_a = key; end
      model(pc, mode, key, sig);
      drive_start(sel, 1'b1);
      tick();
      drive_start(sel, 1'b0);
      done_at = -1; pulses = 0; din_bad = 0; busy_bad = 0; p19 = 0;
      for (int k = 1; k <= pc * per + 4; k++) begin
         tick();
         if (obs(sel, O_DONE) == 1) begin
            pulses++;
            if (done_at < 0) done_at = k;
         end
         if (k <= pc * per) begin
            if (obs(sel, O_DIN) !== 32'(exp_pats[(k - 1) / per])) din_bad++;
            if (obs(sel, O_BUSY) !== 32'(k < pc * per)) busy_bad++;
            if ((k - 1) / per == 18 && (k - 1) % per == 0) p19 = obs(sel, O_DIN);
         end
         drive_start(sel, poke && (k == 2));
      end
      check({tag, "_done_cycle"}, done_at, pc * per);
      check({tag, "_done_pulses"}, pulses, 1);
      check({tag, "_din_seq_errs"}, din_bad, 0);
      check({tag, "_busy_errs"}, busy_bad, 0);
      check({tag, "_sig"}, obs(sel, O_SIG), 32'(sig));
      check({tag, "_pass"}, obs(sel, O_PASS), 32'(sig == '0));
      check({tag, "_pat_idx"}, obs(sel, O_IDX), pc);
      check({tag, "_busy_after"}, obs(sel, O_BUSY), 0);
      if (sel) check({tag, "_pat19_wrap"}, p19, 32'h00801);
   endtask

   initial begin
      logic [OUT_W-1:0] sig2;
      int               pulses;
      logic [31:0]      key;

      ifa.start_i = 0; ifa.abort_i = 0;
      ifb.start_i = 0; ifb.abort_i = 0;

      // Reset state.
      #1;
      check_all_zero("reset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      check_all_zero("post_reset");

      // T2: stuck-at-ones netlist.
      run("t2_stuck", 1'b0, 1, 0, 1'b0);
      check("t2_sig_const", obs(0, O_SIG), 32'h028);

      // T1: identity netlist.
      run("t1_ident", 1'b0, 0, 0, 1'b0);
      check("t1_sig_const", obs(0, O_SIG), 32'h000);
      check("t1_pass_const", obs(0, O_PASS), 1);

      // T4: start pulse during the 2nd pattern is ignored.
      run("t4_poke", 1'b0, 0, 0, 1'b1);

      // T5: abort during the 3rd pattern.
      key = $urandom;
      mode_a = 2; key_a = key;
      model(2, 2, key, sig2);
      drive_start(0, 1'b1);
      tick();
      drive_start(0, 1'b0);
      repeat (4) tick();
      check("t5_busy_before", obs(0, O_BUSY), 1);
      ifa.abort_i = 1'b1;
      tick();
      ifa.abort_i = 1'b0;
      check("t5_busy", obs(0, O_BUSY), 0);
      check("t5_done", obs(0, O_DONE), 0);
      check("t5_pass", obs(0, O_PASS), 0);
      check("t5_pat_idx", obs(0, O_IDX), 2);
      check("t5_sig_partial", obs(0, O_SIG), 32'(sig2));
      check("t5_din_held", obs(0, O_DIN), 32'(exp_pats[1]));
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (obs(0, O_DONE) == 1 || obs(0, O_BUSY) == 1) pulses++;
      end
      check("t5_no_activity", pulses, 0);

      // T3: long run with settle cycles, LFSR wraps on the 19th pattern.
      run("t3_ident", 1'b1, 0, 0, 1'b0);

      // Randomized netlist responses on both instances.
      for (int i = 0; i < 3; i++) run("rnd_b", 1'b1, 2, $urandom, 1'b0);
      for (int i = 0; i < 3; i++) run("rnd_a", 1'b0, 2, $urandom, 1'b0);

      // T6: reset mid-run clears everything immediately, then T1 repeats.
      mode_a = 0;
      drive_start(0, 1'b1);
      tick();
      drive_start(0, 1'b0);
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      check_all_zero("t6_reset");
      #2;
      rst_n = 1'b1;
      tick();
      check("t6_no_done", obs(0, O_DONE), 0);
      run("t6_rerun", 1'b0, 0, 0, 1'b0);
      check("t6_sig_const", obs(0, O_SIG), 32'h000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
